// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode/funct constants, class indices, pc_src codes and fetch states
package cpu_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam int CLS_ADD  = 0;
  localparam int CLS_SUB  = 1;
  localparam int CLS_SLT  = 2;
  localparam int CLS_XORI = 3;
  localparam int CLS_ADDI = 4;
  localparam int CLS_JR   = 5;
  localparam int CLS_JAL  = 6;
  localparam int CLS_J    = 7;
  localparam int CLS_BNE  = 8;
  localparam int CLS_BEQ  = 9;
  localparam int CLS_LW   = 10;
  localparam int CLS_SW   = 11;
  localparam int NCLS     = 12;
  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  localparam logic [1:0] PC_JR  = 2'b11;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/instr_classify.sv
// instr_classify: combinational pre-decode of a 32-bit word into a one-hot class
module instr_classify
  import cpu_pkg::*;
(
  input  logic [31:0]     word,
  output logic [NCLS-1:0] cls,
  output logic            illegal
);
  logic [5:0] op;
  logic [5:0] fn;
  logic       r;
  assign op = word[31:26];
  assign fn = word[5:0];
  assign r  = op == OP_RTYPE;
  assign cls[CLS_ADD]  = r && fn == FN_ADD;
  assign cls[CLS_SUB]  = r && fn == FN_SUB;
  assign cls[CLS_SLT]  = r && fn == FN_SLT;
  assign cls[CLS_JR]   = r && fn == FN_JR;
  assign cls[CLS_XORI] = op == OP_XORI;
  assign cls[CLS_ADDI] = op == OP_ADDI;
  assign cls[CLS_JAL]  = op == OP_JAL;
  assign cls[CLS_J]    = op == OP_J;
  assign cls[CLS_BNE]  = op == OP_BNE;
  assign cls[CLS_BEQ]  = op == OP_BEQ;
  assign cls[CLS_LW]   = op == OP_LW;
  assign cls[CLS_SW]   = op == OP_SW;
  assign illegal = ~|cls;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC/IR owner running one req/ack instruction read per fetch request
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_start,
  input  logic            pc_wr,
  input  logic [1:0]      pc_src,
  input  logic            branch_taken,
  input  logic [31:0]     rs_val,
  output logic            imem_req,
  output logic [31:0]     imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ack,
  output logic            fetch_done,
  output logic            fetch_err,
  output logic [31:0]     pc,
  output logic [31:0]     pc_plus4,
  output logic [31:0]     instr,
  output logic [NCLS-1:0] instr_class,
  output logic            illegal
);
  localparam logic [7:0] T_LAST = 8'(TIMEOUT - 1);
  logic [1:0]      state;
  logic [7:0]      cnt;
  logic [NCLS-1:0] dec_cls;
  logic            dec_ill;
  logic [31:0]     br_off;
  logic [31:0]     next_pc;
  assign imem_req   = state == S_WAIT;
  assign imem_addr  = pc;
  assign fetch_done = state == S_DONE;
  assign pc_plus4   = pc + 32'd4;
  assign br_off     = {{14{instr[15]}}, instr[15:0], 2'b00};
  // next-PC select; JR target is word-aligned by forcing the low bits to zero
  always_comb
    next_pc = pc_src == PC_SEQ ? pc_plus4 :
              pc_src == PC_BR  ? (branch_taken ? pc_plus4 + br_off : pc_plus4) :
              pc_src == PC_JMP ? {pc_plus4[31:28], instr[25:0], 2'b00} :
                                 {rs_val[31:2], 2'b00};
  instr_classify u_cls (
    .word    (imem_rdata),
    .cls     (dec_cls),
    .illegal (dec_ill)
  );
  // fetch FSM: IDLE accepts pc_wr/fetch_start, WAIT holds the request until ack or timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_class <= '0;
      illegal     <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      fetch_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pc_wr) pc <= next_pc;
          if (fetch_start) begin
            state <= S_WAIT;
            cnt   <= '0;
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_class <= dec_cls;
            illegal     <= dec_ill;
            state       <= S_DONE;
          end else if (cnt == T_LAST) begin
            state     <= S_IDLE;
            fetch_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and random fetch/PC checks against a behavioural model
module tb_instr_fetch;
  localparam int TO = 15;
  logic        clk = 0;
  logic        reset = 1;
  logic        fetch_start = 0;
  logic        pc_wr = 0;
  logic [1:0]  pc_src = 0;
  logic        branch_taken = 0;
  logic [31:0] rs_val = 0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 0;
  logic        imem_ack = 0;
  logic        fetch_done;
  logic        fetch_err;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic [11:0] instr_class;
  logic        illegal;
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_pc = 0;
  logic [31:0] m_instr = 0;
  logic [11:0] m_cls = 0;
  logic        m_ill = 0;

  instr_fetch #(.RESET_PC(32'h0), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .fetch_start(fetch_start), .pc_wr(pc_wr),
    .pc_src(pc_src), .branch_taken(branch_taken), .rs_val(rs_val),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .fetch_done(fetch_done), .fetch_err(fetch_err),
    .pc(pc), .pc_plus4(pc_plus4), .instr(instr), .instr_class(instr_class),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // class table straight from the instruction list: returns {illegal, class}
  function automatic logic [12:0] ref_dec(input logic [31:0] w);
    logic [5:0] ops [8] = '{6'h0E, 6'h08, 6'h03, 6'h02, 6'h05, 6'h04, 6'h23, 6'h2B};
    int         opi [8] = '{3, 4, 6, 7, 8, 9, 10, 11};
    logic [5:0] fns [4] = '{6'h20, 6'h22, 6'h2A, 6'h08};
    int         fni [4] = '{0, 1, 2, 5};
    ref_dec = 13'h1000;
    if (w[31:26] == 6'h00) begin
      for (int i = 0; i < 4; i++) if (w[5:0] == fns[i]) ref_dec = 13'(1 << fni[i]);
    end else begin
      for (int i = 0; i < 8; i++) if (w[31:26] == ops[i]) ref_dec = 13'(1 << opi[i]);
    end
  endfunction

  function automatic logic [31:0] rand_word();
    logic [5:0] ops [9] = '{6'h00, 6'h0E, 6'h08, 6'h03, 6'h02, 6'h05, 6'h04, 6'h23, 6'h2B};
    logic [5:0] fns [4] = '{6'h20, 6'h22, 6'h2A, 6'h08};
    logic [31:0] w = $urandom;
    if ($urandom_range(0, 3) != 0) begin
      w[31:26] = ops[$urandom_range(0, 8)];
      if (w[31:26] == 6'h00) w[5:0] = fns[$urandom_range(0, 3)];
    end
    return w;
  endfunction

  function automatic logic [31:0] ref_next(input logic [1:0] src, input logic tk, input logic [31:0] rs);
    logic [31:0]        p4 = m_pc + 32'd4;
    logic signed [31:0] off = $signed(m_instr[15:0]);
    case (src)
      2'd0: return p4;
      2'd1: return tk ? p4 + off * 4 : p4;
      2'd2: return (p4 & 32'hF000_0000) + {6'b0, m_instr[25:0]} * 4;
      default: return rs - (rs % 4);
    endcase
  endfunction

  task automatic arm_wr(input logic [1:0] src, input logic tk, input logic [31:0] rs);
    pc_wr = 1; pc_src = src; branch_taken = tk; rs_val = rs;
    m_pc = ref_next(src, tk, rs);
  endtask

  task automatic commit(input logic [1:0] src, input logic tk, input logic [31:0] rs);
    arm_wr(src, tk, rs);
    @(negedge clk);
    pc_wr = 0;
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
  endtask

  // k in 1..TO: ack in WAIT cycle k; otherwise no ack and the fetch times out
  task automatic do_fetch(input logic [31:0] rd, input int k);
    logic [31:0] a0;
    fetch_start = 1;
    @(negedge clk);
    fetch_start = 0;
    pc_wr = 0;
    a0 = m_pc;
    for (int j = 1; j <= TO; j++) begin
      chk("wait_req", {31'b0, imem_req}, 1);
      chk("wait_addr", imem_addr, a0);
      chk("wait_done", {31'b0, fetch_done}, 0);
      chk("wait_err", {31'b0, fetch_err}, 0);
      fetch_start = $urandom_range(0, 1);
      pc_wr = $urandom_range(0, 1);
      pc_src = 2'd3;
      rs_val = $urandom;
      imem_ack = j == k;
      imem_rdata = j == k ? rd : $urandom;
      @(negedge clk);
      imem_ack = 0;
      fetch_start = 0;
      pc_wr = 0;
      if (j == k) break;
    end
    if (k >= 1 && k <= TO) begin
      {m_ill, m_cls} = ref_dec(rd);
      m_instr = rd;
      chk("done", {31'b0, fetch_done}, 1);
      chk("instr", instr, m_instr);
      chk("class", {20'b0, instr_class}, {20'b0, m_cls});
      chk("illegal", {31'b0, illegal}, {31'b0, m_ill});
      chk("done_req", {31'b0, imem_req}, 0);
      fetch_start = 1;
      pc_wr = 1;
      pc_src = 2'd3;
      rs_val = $urandom;
      @(negedge clk);
      fetch_start = 0;
      pc_wr = 0;
      chk("done_pulse", {31'b0, fetch_done}, 0);
      chk("done_ignore_start", {31'b0, imem_req}, 0);
      chk("done_ignore_pcwr", pc, m_pc);
    end else begin
      chk("err", {31'b0, fetch_err}, 1);
      chk("err_req", {31'b0, imem_req}, 0);
      chk("err_instr", instr, m_instr);
      chk("err_done", {31'b0, fetch_done}, 0);
      imem_ack = 1;
      imem_rdata = rd;
      @(negedge clk);
      imem_ack = 0;
      chk("err_pulse", {31'b0, fetch_err}, 0);
      chk("late_ack_done", {31'b0, fetch_done}, 0);
      chk("late_ack_instr", instr, m_instr);
      chk("late_ack_class", {20'b0, instr_class}, {20'b0, m_cls});
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 0;
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_class", {20'b0, instr_class}, 32'h0);
    chk("rst_illegal", {31'b0, illegal}, 0);
    chk("rst_req", {31'b0, imem_req}, 0);
    chk("rst_done", {31'b0, fetch_done}, 0);
    chk("rst_err", {31'b0, fetch_err}, 0);
    do_fetch(32'h012A4020, 1);
    chk("add_class", {20'b0, instr_class}, 32'h001);
    chk("add_pc", pc, 32'h0);
    do_fetch(32'h8C220004, 3);
    chk("lw_class", {20'b0, instr_class}, 32'h400);
    commit(2'd3, 0, 32'h40);
    do_fetch(32'h1000FFFF, 2);
    commit(2'd1, 1, 32'h0);
    chk("beq_taken", pc, 32'h40);
    commit(2'd1, 0, 32'h0);
    chk("beq_not_taken", pc, 32'h44);
    commit(2'd3, 0, 32'h1003);
    chk("jr_align", pc, 32'h1000);
    commit(2'd3, 0, 32'hFFFF_FFFF);
    commit(2'd0, 0, 32'h0);
    chk("pc_wrap", pc, 32'h0);
    do_fetch(32'h0800_1234, 0);
    do_fetch(32'hFC00_0000, TO);
    chk("illegal_set", {31'b0, illegal}, 1);
    chk("illegal_class", {20'b0, instr_class}, 0);
    arm_wr(2'd3, 0, 32'h2468);
    do_fetch(32'h0800_0010, 1);
    commit(2'd2, 0, 32'h0);
    fetch_start = 1;
    @(negedge clk);
    fetch_start = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    m_pc = 0; m_instr = 0; m_cls = 0; m_ill = 0;
    chk("midrst_req", {31'b0, imem_req}, 0);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_instr", instr, 32'h0);
    chk("midrst_done", {31'b0, fetch_done}, 0);
    imem_ack = 1;
    imem_rdata = 32'h012A4020;
    @(negedge clk);
    imem_ack = 0;
    chk("postrst_done", {31'b0, fetch_done}, 0);
    chk("postrst_instr", instr, 32'h0);
    chk("postrst_req", {31'b0, imem_req}, 0);
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0: do_fetch(rand_word(), $urandom_range(0, 5) == 0 ? 0 : int'($urandom_range(1, TO)));
        1: commit(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
        default: begin
          arm_wr(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
          do_fetch(rand_word(), int'($urandom_range(1, 4)));
        end
      endcase
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
